// File: rtl/decode_event_fifo_pkg.sv
// Shared types and sizing for the decode event FIFO.
// Code width must track the upstream priority decoder.
package decode_event_fifo_pkg;

    localparam int CODE_W = 2;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [LVL_W-1:0]  lvl_t;

    // DEPTH is a power of two, so a plain increment wraps modulo DEPTH.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/decode_event_fifo_if.sv
// Consumer-side valid/ready handshake carrying one decoded event code.
interface decode_event_fifo_if;
    import decode_event_fifo_pkg::*;

    code_t out_code;
    logic  out_valid;
    logic  out_ready;

    // The FIFO drives code/valid and observes ready.
    modport master (output out_code, output out_valid, input out_ready);
    // The consumer observes code/valid and drives ready.
    modport slave  (input out_code, input out_valid, output out_ready);

endinterface

// File: rtl/decode_event_fifo_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: storage, wrapping pointers,
// a separate occupancy counter, and registered full/empty/valid flags.
module sync_fifo_fwft
    import decode_event_fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en,
    input  code_t wr_data,
    input  logic  rd_en,
    output code_t rd_data,
    output logic  valid,
    output lvl_t  level,
    output logic  full,
    output logic  empty
);

    code_t mem_q [DEPTH];
    code_t mem_d [DEPTH];
    ptr_t  wr_ptr_q, wr_ptr_d;
    ptr_t  rd_ptr_q, rd_ptr_d;
    lvl_t  level_q, level_d;
    logic  full_q, full_d;
    logic  empty_q, empty_d;
    logic  valid_q, valid_d;
    logic  do_rd;
    logic  do_wr;

    // Next-state: a pop frees a slot in the same cycle, so a write to a full FIFO succeeds alongside it.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        do_rd    = rd_en & ~empty_q;
        do_wr    = wr_en & (~full_q | do_rd);

        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_rd) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + lvl_t'(1);
            2'b01:   level_d = level_q - lvl_t'(1);
            default: level_d = level_q;
        endcase

        full_d  = (level_d == lvl_t'(DEPTH));
        empty_d = (level_d == '0);
        valid_d = ~empty_d;
    end

    // State registers; reset flushes every entry in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: storage is reset too, because the head code must read 0 out of reset and the array is tiny.
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            valid_q  <= valid_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign valid   = valid_q;
    assign level   = level_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/decode_event_fifo.sv
// Converts level outputs of the priority decoder into discrete queued events,
// with sticky overflow and a saturating drop counter.
module decode_event_fifo
    import decode_event_fifo_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  code_t                decode_in,
    input  logic                 legal_in,
    decode_event_fifo_if.master  out_if,
    output lvl_t                 level,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    input  logic                 clr_ovf,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             last_legal_q, last_legal_d;
    code_t            last_code_q,  last_code_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             evt;
    logic             pop;
    logic             drop;
    logic             fifo_valid;
    logic             fifo_full;
    code_t            fifo_code;

    sync_fifo_fwft u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (evt),
        .wr_data (decode_in),
        .rd_en   (pop),
        .rd_data (fifo_code),
        .valid   (fifo_valid),
        .level   (level),
        .full    (fifo_full),
        .empty   (empty)
    );

    // Change detection and overflow bookkeeping; a clear in the same cycle as a drop wins.
    always_comb begin
        evt  = legal_in & (~last_legal_q | (decode_in != last_code_q));
        pop  = fifo_valid & out_if.out_ready;
        drop = evt & fifo_full & ~pop;

        last_legal_d = legal_in;
        last_code_d  = decode_in;
        ovf_d        = ovf_q;
        drop_cnt_d   = drop_cnt_q;

        if (clr_ovf) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    // Detector history and overflow state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_legal_q <= 1'b0;
            last_code_q  <= '0;
            ovf_q        <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            last_legal_q <= last_legal_d;
            last_code_q  <= last_code_d;
            ovf_q        <= ovf_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign out_if.out_code  = fifo_code;
    assign out_if.out_valid = fifo_valid;
    assign full             = fifo_full;
    assign overflow         = ovf_q;
    assign drop_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_decode_event_fifo.sv
// Scoreboard bench for decode_event_fifo: a queue-based reference model
// tracks expected contents; a negedge monitor compares the DUT against it.
module tb_decode_event_fifo;
    import decode_event_fifo_pkg::*;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    code_t            decode_in;
    logic             legal_in;
    logic             clr_ovf;
    lvl_t             level;
    logic             full;
    logic             empty;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    decode_event_fifo_if u_if ();

    decode_event_fifo #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .decode_in (decode_in),
        .legal_in  (legal_in),
        .out_if    (u_if),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected FIFO contents as a queue, plus overflow state.
    code_t exp_q [$];
    bit    m_ovf        = 1'b0;
    int    m_cnt        = 0;
    bit    m_last_legal = 1'b0;
    code_t m_last_code  = '0;
    bit    started      = 1'b0;

    // Model update at each active edge; pops were already applied by the monitor.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_ovf        = 1'b0;
            m_cnt        = 0;
            m_last_legal = 1'b0;
            m_last_code  = '0;
        end else begin
            if (legal_in && (!m_last_legal || decode_in != m_last_code)) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(decode_in);
                end else if (!clr_ovf) begin
                    m_ovf = 1'b1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
            end
            if (clr_ovf) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
            m_last_legal = legal_in;
            m_last_code  = decode_in;
        end
        started = 1'b1;
    end

    // Monitor: compare the DUT to the model mid-cycle; retire the head on a handshake.
    always @(negedge clk) begin
        if (started) begin
            check("level",     32'(level),         32'(exp_q.size()));
            check("empty",     32'(empty),         32'(exp_q.size() == 0));
            check("full",      32'(full),          32'(exp_q.size() == DEPTH));
            check("out_valid", 32'(u_if.out_valid), 32'(exp_q.size() != 0));
            check("overflow",  32'(overflow),      32'(m_ovf));
            check("drop_cnt",  32'(drop_cnt),      32'(m_cnt));
            if (exp_q.size() != 0) begin
                check("out_code", 32'(u_if.out_code), 32'(exp_q[0]));
                if (u_if.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        code_t seq2 [4];
        code_t seq3 [5];
        int    ready_pct;

        rst            = 1'b1;
        legal_in       = 1'b0;
        decode_in      = '0;
        clr_ovf        = 1'b0;
        u_if.out_ready = 1'b0;
        step();
        step();
        check("rst_level",    32'(level),         32'd0);
        check("rst_empty",    32'(empty),         32'd1);
        check("rst_full",     32'(full),          32'd0);
        check("rst_valid",    32'(u_if.out_valid), 32'd0);
        check("rst_out_code", 32'(u_if.out_code),  32'd0);
        check("rst_overflow", 32'(overflow),      32'd0);
        check("rst_drop_cnt", 32'(drop_cnt),      32'd0);
        rst = 1'b0;
        step();

        // Held legal code yields exactly one event, visible one edge later.
        legal_in  = 1'b1;
        decode_in = 2'b10;
        step();
        check("t1_valid", 32'(u_if.out_valid), 32'd1);
        check("t1_code",  32'(u_if.out_code),  32'd2);
        check("t1_level", 32'(level),         32'd1);
        repeat (4) step();
        check("t1_level_held", 32'(level), 32'd1);
        legal_in       = 1'b0;
        u_if.out_ready = 1'b1;
        repeat (2) step();
        check("t1_drained", 32'(empty), 32'd1);

        // Repeated code collapses; three entries queued then drained in order.
        u_if.out_ready = 1'b0;
        legal_in       = 1'b1;
        seq2           = '{2'b01, 2'b11, 2'b11, 2'b00};
        foreach (seq2[i]) begin
            decode_in = seq2[i];
            step();
        end
        check("t2_level", 32'(level),        32'd3);
        check("t2_head",  32'(u_if.out_code), 32'd1);
        u_if.out_ready = 1'b1;
        repeat (3) step();
        check("t2_empty", 32'(empty), 32'd1);
        legal_in = 1'b0;
        step();

        // Five events into a four-deep FIFO: one drop.
        u_if.out_ready = 1'b0;
        legal_in       = 1'b1;
        seq3           = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        foreach (seq3[i]) begin
            decode_in = seq3[i];
            step();
        end
        check("t3_full",     32'(full),          32'd1);
        check("t3_level",    32'(level),         32'd4);
        check("t3_overflow", 32'(overflow),      32'd1);
        check("t3_drop_cnt", 32'(drop_cnt),      32'd1);
        check("t3_head",     32'(u_if.out_code), 32'd1);

        // Full with simultaneous pop and event: write accepted, no new drop.
        decode_in      = 2'b10;
        u_if.out_ready = 1'b1;
        step();
        check("t4_level",    32'(level),         32'd4);
        check("t4_overflow", 32'(overflow),      32'd1);
        check("t4_drop_cnt", 32'(drop_cnt),      32'd1);
        check("t4_head",     32'(u_if.out_code), 32'd2);

        // Reset mid-operation flushes; a still-held legal code re-fires after.
        legal_in = 1'b0;
        step();
        check("t5_level_pre", 32'(level), 32'd3);
        u_if.out_ready = 1'b0;
        legal_in       = 1'b1;
        decode_in      = 2'b11;
        rst            = 1'b1;
        step();
        check("t5_rst_level", 32'(level),         32'd0);
        check("t5_rst_valid", 32'(u_if.out_valid), 32'd0);
        rst = 1'b0;
        step();
        check("t5_level", 32'(level),        32'd1);
        check("t5_code",  32'(u_if.out_code), 32'd3);

        // Many drops saturate the counter; clear beats a coincident drop.
        for (int i = 0; i < 310; i++) begin
            decode_in = code_t'(i % 2);
            step();
        end
        check("t6_drop_sat", 32'(drop_cnt), 32'd255);
        check("t6_overflow", 32'(overflow), 32'd1);
        decode_in = ~decode_in;
        clr_ovf   = 1'b1;
        step();
        check("t6_clr_cnt", 32'(drop_cnt), 32'd0);
        check("t6_clr_ovf", 32'(overflow), 32'd0);
        clr_ovf        = 1'b0;
        legal_in       = 1'b0;
        u_if.out_ready = 1'b1;
        repeat (6) step();

        // Randomized traffic with varying consumer back-pressure.
        ready_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) ready_pct = $urandom_range(10, 90);
            legal_in       = ($urandom_range(0, 3) != 0);
            decode_in      = code_t'($urandom_range(0, 3));
            u_if.out_ready = ($urandom_range(0, 99) < ready_pct);
            clr_ovf        = ($urandom_range(0, 63) == 0);
            rst            = ($urandom_range(0, 499) == 0);
            step();
        end
        rst            = 1'b0;
        clr_ovf        = 1'b0;
        legal_in       = 1'b0;
        u_if.out_ready = 1'b1;
        repeat (8) step();
        check("final_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
